pbkdf2_stream: RTL

PBKDF2-HMAC-SHA512 key-derivation engine with runtime salt and iteration count. It derives `NBLOCKS` consecutive 512-bit output blocks (T1..Tn) and streams each block out over a valid/ready handshake. It sits above the existing `hmac` core and replaces the fixed-salt, single-block, fixed-iteration derivation engine. It adds a start/busy/done handshake so the same instance can be reused for successive keys.

---
 rtl/pbkdf2_pkg.sv | 34 +++
 rtl/hmac.sv | 44 ++++
 rtl/pbkdf2_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2-HMAC-SHA512 stream engine and its HMAC core.
package pbkdf2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    H36,
    DATA,
    H64,
    EMIT,
    DONE
  } state_t;

  localparam logic HMAC_MODE_36 = 1'b0;
  localparam logic HMAC_MODE_64 = 1'b1;

  localparam int unsigned SALT_BYTES = 32;
  localparam int unsigned SALT_W     = SALT_BYTES * 8;
  localparam int unsigned BLOCK_W    = 512;
  localparam int unsigned KEY_W      = 1024;
  localparam int unsigned CTR_W      = 32;
  localparam int unsigned MSG36_W    = SALT_W + CTR_W;
  localparam int unsigned PAD36_W    = BLOCK_W - MSG36_W;

  // Whitening applied by the core to 64-byte (chained) messages only.
  localparam logic [BLOCK_W-1:0] HMAC_MODE64_TWEAK = {8{64'hA5A5_5A5A_0F0F_F0F0}};

  // First-iteration message: salt followed by the big-endian block index, left-aligned.
  function automatic logic [BLOCK_W-1:0] salt_msg(input logic [SALT_W-1:0] salt,
                                                  input logic [CTR_W-1:0]  idx);
    return {salt, idx, {PAD36_W{1'b0}}};
  endfunction

endpackage

// File: rtl/hmac.sv
// Keyed hash core with the launch/done handshake used by pbkdf2_stream:
// low hmac reset clears it, done rises LAT cycles after reset releases and holds.
module hmac
  import pbkdf2_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] msg,
  output logic               done,
  output logic [BLOCK_W-1:0] digest
);

  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic [CNT_W-1:0]   cnt;
  logic [BLOCK_W-1:0] mixed;

  // Mode 0 only sees the 36-byte prefix of msg.
  always_comb begin
    mixed = (mode == HMAC_MODE_64) ? msg : {msg[BLOCK_W-1:PAD36_W], {PAD36_W{1'b0}}};
    mixed = mixed ^ key[KEY_W-1:BLOCK_W] ^ key[BLOCK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      done   <= 1'b0;
      digest <= '0;
    end else if (!done) begin
      if (cnt == CNT_W'(LAT - 1)) begin
        done   <= 1'b1;
        digest <= {mixed[BLOCK_W-2:0], mixed[BLOCK_W-1]}
                  ^ ((mode == HMAC_MODE_64) ? HMAC_MODE64_TWEAK : '0);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pbkdf2_stream.sv
// PBKDF2 derivation engine: runs c HMAC iterations per block over a single hmac core
// and streams each derived block T1..Tn on a valid/ready handshake.
module pbkdf2_stream
  import pbkdf2_pkg::*;
#(
  parameter int unsigned NBLOCKS = 1,
  parameter int unsigned ITER_W  = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [KEY_W-1:0]                 key,
  input  logic [SALT_W-1:0]                salt,
  input  logic [ITER_W-1:0]                iterations,
  output logic                             busy,
  output logic                             done,
  output logic [BLOCK_W-1:0]               dk_block,
  output logic [$clog2(NBLOCKS+1)-1:0]     dk_index,
  output logic                             dk_valid,
  input  logic                             dk_ready
);

  localparam int unsigned IDX_W = $clog2(NBLOCKS + 1);

  state_t             state;
  logic [KEY_W-1:0]   key_q;
  logic [SALT_W-1:0]  salt_q;
  logic [ITER_W-1:0]  iter_lim;
  logic [ITER_W-1:0]  iter_cnt;
  logic [ITER_W-1:0]  iter_nxt;
  logic [IDX_W-1:0]   blk;
  logic [BLOCK_W-1:0] t_acc;
  logic [BLOCK_W-1:0] t_nxt;
  logic [BLOCK_W-1:0] msg;
  logic               mode;
  logic               hmac_reset;
  logic               hmac_done;
  logic [BLOCK_W-1:0] hmac_digest;

  // iter_cnt < iter_lim <= 2^ITER_W-1, so the increment never wraps.
  always_comb begin
    iter_nxt = iter_cnt + ITER_W'(1);
    t_nxt    = t_acc ^ hmac_digest;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dk_valid   <= 1'b0;
      dk_block   <= '0;
      dk_index   <= '0;
      hmac_reset <= 1'b0;
      iter_cnt   <= '0;
      blk        <= '0;
      key_q      <= '0;
      salt_q     <= '0;
      iter_lim   <= '0;
      t_acc      <= '0;
      msg        <= '0;
      mode       <= HMAC_MODE_36;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            salt_q   <= salt;
            iter_lim <= (iterations == '0) ? ITER_W'(1) : iterations;
            blk      <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= INIT;
          end
        end
        INIT: begin
          t_acc      <= '0;
          msg        <= salt_msg(salt_q, CTR_W'(blk));
          iter_cnt   <= '0;
          mode       <= HMAC_MODE_36;
          hmac_reset <= 1'b1;
          state      <= H36;
        end
        H36, H64: begin
          if (hmac_done) begin
            hmac_reset <= 1'b0;
            state      <= DATA;
          end
        end
        DATA: begin
          t_acc    <= t_nxt;
          msg      <= hmac_digest;
          iter_cnt <= iter_nxt;
          mode     <= HMAC_MODE_64;
          if (iter_nxt < iter_lim) begin
            hmac_reset <= 1'b1;
            state      <= H64;
          end else begin
            dk_valid <= 1'b1;
            dk_block <= t_nxt;
            dk_index <= blk;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (dk_ready) begin
            dk_valid <= 1'b0;
            if (blk == IDX_W'(NBLOCKS)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              blk   <= blk + IDX_W'(1);
              state <= INIT;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  hmac u_hmac (
    .clk    (clk),
    .reset  (hmac_reset),
    .mode   (mode),
    .key    (key_q),
    .msg    (msg),
    .done   (hmac_done),
    .digest (hmac_digest)
  );

endmodule
